// File: rtl/rvc_asap_pkg.sv
// Shared types, constants and register macros for the rvc_asap core and its boot controller.
`ifndef RVC_RST_MSFF
`define RVC_RST_MSFF(q, i, clk, rst, rstVal) \
    always_ff @(posedge clk) begin \
        if (rst) q <= rstVal; \
        else     q <= i; \
    end
`endif

`ifndef RVC_EN_MSFF
`define RVC_EN_MSFF(q, i, clk, en) \
    always_ff @(posedge clk) begin \
        if (en) q <= i; \
    end
`endif

package rvc_asap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } t_boot_state;

    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_SYS     = 2'd1,
        HC_STOP    = 2'd2,
        HC_TIMEOUT = 2'd3
    } t_halt_cause;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
    localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;

endpackage

// File: rtl/rvc_asap_boot_ctrl.sv
// Boot/run controller: streams a program image into I_MEM with the core held in reset,
// then runs the core until EBREAK/ECALL, an external stop or the cycle budget ends the run.
module rvc_asap_boot_ctrl
    import rvc_asap_pkg::*;
#(
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] MAX_CYCLES = 32'hFFFF_FFFF
) (
    input  logic                        Clock,
    input  logic                        Rst,
    input  logic                        LoadStart,
    input  logic [$clog2(IMEM_DEPTH):0] LoadLen,
    input  logic                        LoadValid,
    input  logic [31:0]                 LoadData,
    output logic                        LoadReady,
    input  logic                        StopReq,
    output logic                        ImemWrEn,
    output logic [31:0]                 ImemWrAddr,
    output logic [31:0]                 ImemWrData,
    output logic                        CoreRst,
    input  logic [31:0]                 Pc_From_Core,
    input  logic [31:0]                 Instruction_From_Imem,
    output logic                        Halted,
    output logic [1:0]                  HaltCause,
    output logic [31:0]                 HaltPc,
    output logic [31:0]                 CycleCount
);

    localparam int          LEN_W      = $clog2(IMEM_DEPTH) + 1;
    localparam logic [31:0] TIMEOUT_AT = MAX_CYCLES - 32'd1;

    t_boot_state       stateReg,      stateNext;
    t_halt_cause       haltCauseReg,  haltCauseNext;
    logic [LEN_W-1:0]  wordCntReg,    wordCntNext;
    logic [LEN_W-1:0]  lenReg,        lenNext;
    logic              lenEn;
    logic [31:0]       cycleCountReg, cycleCountNext;
    logic [31:0]       haltPcReg,     haltPcNext;
    logic              coreRstReg,    coreRstNext;
    logic              haltedReg,     haltedNext;
    logic [LEN_W-1:0]  clampedLen;
    logic              sysHit;

    assign clampedLen = (LoadLen > LEN_W'(IMEM_DEPTH)) ? LEN_W'(IMEM_DEPTH) : LoadLen;
    assign sysHit     = (Instruction_From_Imem == EBREAK_INSTR) ||
                        (Instruction_From_Imem == ECALL_INSTR);

    // Loader-facing outputs decode straight from state so the write lands on the handshake edge.
    assign LoadReady  = (stateReg == LOAD);
    assign ImemWrEn   = LoadReady && LoadValid;
    assign ImemWrAddr = {{(32-LEN_W){1'b0}}, wordCntReg} << 2;
    assign ImemWrData = LoadData;

    always_comb begin
        stateNext      = stateReg;
        haltCauseNext  = haltCauseReg;
        wordCntNext    = wordCntReg;
        lenNext        = lenReg;
        lenEn          = 1'b0;
        cycleCountNext = cycleCountReg;
        haltPcNext     = haltPcReg;

        case (stateReg)
            IDLE, HALT: begin
                if (LoadStart) begin
                    lenEn          = 1'b1;
                    lenNext        = clampedLen;
                    wordCntNext    = '0;
                    cycleCountNext = '0;
                    haltCauseNext  = HC_NONE;
                    haltPcNext     = '0;
                    stateNext      = (clampedLen != '0) ? LOAD : RUN;
                end
            end
            LOAD: begin
                if (ImemWrEn) begin
                    wordCntNext = wordCntReg + 1'b1;
                    if (wordCntReg == lenReg - 1'b1) begin
                        stateNext = RUN;
                    end
                end
            end
            RUN: begin
                cycleCountNext = cycleCountReg + 32'd1;
                // Priority: system instruction, then external stop, then budget timeout.
                if (sysHit) begin
                    stateNext     = HALT;
                    haltCauseNext = HC_SYS;
                    haltPcNext    = Pc_From_Core;
                end else if (StopReq) begin
                    stateNext     = HALT;
                    haltCauseNext = HC_STOP;
                    haltPcNext    = Pc_From_Core;
                end else if (cycleCountReg == TIMEOUT_AT) begin
                    stateNext     = HALT;
                    haltCauseNext = HC_TIMEOUT;
                    haltPcNext    = Pc_From_Core;
                end
            end
            default: stateNext = IDLE;
        endcase

        coreRstNext = (stateNext != RUN);
        haltedNext  = (stateNext == HALT);
    end

    `RVC_RST_MSFF(stateReg,      stateNext,      Clock, Rst, IDLE)
    `RVC_RST_MSFF(haltCauseReg,  haltCauseNext,  Clock, Rst, HC_NONE)
    `RVC_RST_MSFF(wordCntReg,    wordCntNext,    Clock, Rst, '0)
    `RVC_RST_MSFF(cycleCountReg, cycleCountNext, Clock, Rst, 32'd0)
    `RVC_RST_MSFF(haltPcReg,     haltPcNext,     Clock, Rst, 32'd0)
    `RVC_RST_MSFF(coreRstReg,    coreRstNext,    Clock, Rst, 1'b1)
    `RVC_RST_MSFF(haltedReg,     haltedNext,     Clock, Rst, 1'b0)
    `RVC_EN_MSFF(lenReg,         lenNext,        Clock, lenEn)

    assign CoreRst    = coreRstReg;
    assign Halted     = haltedReg;
    assign HaltCause  = haltCauseReg;
    assign HaltPc     = haltPcReg;
    assign CycleCount = cycleCountReg;

endmodule

// File: tb/tb_rvc_asap_boot_ctrl.sv
// Directed bench for rvc_asap_boot_ctrl with a behavioural I_MEM and a straight-line fetch model.
module tb_rvc_asap_boot_ctrl;

    localparam int LEN_W = 11;

    logic              Clock = 1'b0;
    logic              Rst = 1'b1;
    logic              LoadStart = 1'b0;
    logic [LEN_W-1:0]  LoadLen = '0;
    logic              LoadValid = 1'b0;
    logic [31:0]       LoadData = '0;
    logic              LoadReady;
    logic              StopReq = 1'b0;
    logic              ImemWrEn;
    logic [31:0]       ImemWrAddr;
    logic [31:0]       ImemWrData;
    logic              CoreRst;
    logic [31:0]       Pc_From_Core = '0;
    logic [31:0]       Instruction_From_Imem;
    logic              Halted;
    logic [1:0]        HaltCause;
    logic [31:0]       HaltPc;
    logic [31:0]       CycleCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];

    rvc_asap_boot_ctrl #(.IMEM_DEPTH(1024), .MAX_CYCLES(32'd10)) dut (
        .Clock(Clock), .Rst(Rst), .LoadStart(LoadStart), .LoadLen(LoadLen),
        .LoadValid(LoadValid), .LoadData(LoadData), .LoadReady(LoadReady),
        .StopReq(StopReq), .ImemWrEn(ImemWrEn), .ImemWrAddr(ImemWrAddr),
        .ImemWrData(ImemWrData), .CoreRst(CoreRst), .Pc_From_Core(Pc_From_Core),
        .Instruction_From_Imem(Instruction_From_Imem), .Halted(Halted),
        .HaltCause(HaltCause), .HaltPc(HaltPc), .CycleCount(CycleCount)
    );

    always #5 Clock = ~Clock;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
    end

    always @(posedge Clock) begin
        if (ImemWrEn) mem[ImemWrAddr[11:2]] <= ImemWrData;
        Pc_From_Core <= CoreRst ? 32'd0 : Pc_From_Core + 32'd4;
    end

    assign Instruction_From_Imem = mem[Pc_From_Core[11:2]];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic waitHalt();
        for (int n = 0; n < 40 && !Halted; n++) tick();
        chk("halt_reached", {31'd0, Halted}, 32'd1);
        $display("halt: cause=%0d pc=%h cycles=%0d", HaltCause, HaltPc, CycleCount);
    endtask

    task automatic startLoad(input logic [LEN_W-1:0] len);
        LoadStart = 1'b1;
        LoadLen   = len;
        tick();
        LoadStart = 1'b0;
    endtask

    task automatic pushWord(input logic [31:0] data, input logic [31:0] expAddr, input string tag);
        LoadValid = 1'b1;
        LoadData  = data;
        #1;
        chk({tag, "_wren"}, {31'd0, ImemWrEn}, 32'd1);
        chk({tag, "_addr"}, ImemWrAddr, expAddr);
        chk({tag, "_data"}, ImemWrData, data);
        chk({tag, "_corerst"}, {31'd0, CoreRst}, 32'd1);
        $display("load word: addr=%h data=%h", ImemWrAddr, ImemWrData);
        tick();
    endtask

    initial begin
        int          nWr;
        int          nBad;
        logic [31:0] lastAddr;
        logic        pat [4];

        // Reset state
        tick(); tick();
        chk("rst_corerst", {31'd0, CoreRst}, 32'd1);
        chk("rst_ready", {31'd0, LoadReady}, 32'd0);
        chk("rst_wren", {31'd0, ImemWrEn}, 32'd0);
        chk("rst_halted", {31'd0, Halted}, 32'd0);
        chk("rst_cause", {30'd0, HaltCause}, 32'd0);
        chk("rst_haltpc", HaltPc, 32'd0);
        chk("rst_cycles", CycleCount, 32'd0);
        Rst = 1'b0;
        tick();

        // Three-word program ending in EBREAK
        startLoad(11'd3);
        pushWord(32'h0050_0093, 32'h0, "t1w0");
        pushWord(32'h0010_8113, 32'h4, "t1w1");
        pushWord(32'h0010_0073, 32'h8, "t1w2");
        LoadValid = 1'b0;
        #1;
        chk("t1_run_corerst", {31'd0, CoreRst}, 32'd0);
        chk("t1_run_ready", {31'd0, LoadReady}, 32'd0);
        waitHalt();
        chk("t1_cause", {30'd0, HaltCause}, 32'd1);
        chk("t1_haltpc", HaltPc, 32'h8);
        chk("t1_cycles", CycleCount, 32'd3);
        chk("t1_corerst", {31'd0, CoreRst}, 32'd1);

        // Gapped loader stream 1,0,0,1 over two words; word 2 keeps the old EBREAK
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        startLoad(11'd2);
        chk("t2_cause_cleared", {30'd0, HaltCause}, 32'd0);
        nWr = 0;
        for (int i = 0; i < 4; i++) begin
            LoadValid = pat[i];
            LoadData  = 32'h0000_0013;
            #1;
            chk("t2_wren", {31'd0, ImemWrEn}, {31'd0, pat[i]});
            chk("t2_corerst", {31'd0, CoreRst}, 32'd1);
            if (pat[i]) begin
                chk("t2_addr", ImemWrAddr, 32'(nWr * 4));
                nWr++;
            end
            tick();
        end
        LoadValid = 1'b0;
        #1;
        chk("t2_run_corerst", {31'd0, CoreRst}, 32'd0);
        waitHalt();
        chk("t2_cause", {30'd0, HaltCause}, 32'd1);
        chk("t2_haltpc", HaltPc, 32'h8);

        // Len==0 rerun; StopReq coincides with the EBREAK fetch
        startLoad(11'd0);
        chk("t3_run_corerst", {31'd0, CoreRst}, 32'd0);
        chk("t3_cycles_cleared", CycleCount, 32'd0);
        tick();
        tick();
        StopReq = 1'b1;
        tick();
        StopReq = 1'b0;
        chk("t3_halted", {31'd0, Halted}, 32'd1);
        chk("t3_cause", {30'd0, HaltCause}, 32'd1);
        chk("t3_haltpc", HaltPc, 32'h8);
        chk("t3_cycles", CycleCount, 32'd3);

        // StopReq alone, then StopReq while halted does nothing
        startLoad(11'd0);
        tick();
        StopReq = 1'b1;
        tick();
        chk("t4_halted", {31'd0, Halted}, 32'd1);
        chk("t4_cause", {30'd0, HaltCause}, 32'd2);
        chk("t4_haltpc", HaltPc, 32'h4);
        chk("t4_cycles", CycleCount, 32'd2);
        tick();
        StopReq = 1'b0;
        chk("t4_hold_cause", {30'd0, HaltCause}, 32'd2);
        chk("t4_hold_cycles", CycleCount, 32'd2);

        // NOP-only program hits the 10-cycle budget
        startLoad(11'd4);
        for (int i = 0; i < 4; i++) pushWord(32'h0000_0013, 32'(i * 4), "t5w");
        LoadValid = 1'b0;
        waitHalt();
        chk("t5_cause", {30'd0, HaltCause}, 32'd3);
        chk("t5_cycles", CycleCount, 32'd10);
        chk("t5_haltpc", HaltPc, 32'h24);

        // Oversized length clamps to the full I_MEM
        startLoad(11'd2000);
        nWr = 0; nBad = 0; lastAddr = '0;
        LoadValid = 1'b1;
        LoadData  = 32'h0000_0013;
        for (int i = 0; i < 1024; i++) begin
            #1;
            if (!ImemWrEn || ImemWrAddr != 32'(i * 4)) nBad++;
            if (ImemWrEn) begin
                nWr++;
                lastAddr = ImemWrAddr;
            end
            tick();
        end
        LoadValid = 1'b0;
        #1;
        $display("bulk load: writes=%0d last=%h", nWr, lastAddr);
        chk("t6_writes", 32'(nWr), 32'd1024);
        chk("t6_bad", 32'(nBad), 32'd0);
        chk("t6_lastaddr", lastAddr, 32'hFFC);
        chk("t6_run_corerst", {31'd0, CoreRst}, 32'd0);
        chk("t6_ready", {31'd0, LoadReady}, 32'd0);
        waitHalt();

        // Reset in the middle of a load, then reload from address 0
        startLoad(11'd8);
        for (int i = 0; i < 5; i++) pushWord(32'h0000_0013, 32'(i * 4), "t7w");
        Rst = 1'b1;
        tick();
        #1;
        chk("t7_corerst", {31'd0, CoreRst}, 32'd1);
        chk("t7_ready", {31'd0, LoadReady}, 32'd0);
        chk("t7_wren", {31'd0, ImemWrEn}, 32'd0);
        chk("t7_halted", {31'd0, Halted}, 32'd0);
        chk("t7_cause", {30'd0, HaltCause}, 32'd0);
        chk("t7_haltpc", HaltPc, 32'd0);
        chk("t7_cycles", CycleCount, 32'd0);
        LoadValid = 1'b0;
        Rst = 1'b0;
        tick();
        startLoad(11'd1);
        pushWord(32'h0010_0073, 32'h0, "t7r");
        LoadValid = 1'b0;
        #1;
        chk("t7_run_corerst", {31'd0, CoreRst}, 32'd0);
        waitHalt();
        chk("t7_halt_cause", {30'd0, HaltCause}, 32'd1);
        chk("t7_halt_pc", HaltPc, 32'h0);
        chk("t7_halt_cycles", CycleCount, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvc_asap_boot_ctrl.md
# rvc_asap_boot_ctrl

Boot and run controller for the single-cycle rvc_asap core. Loads a program image from a valid/ready word stream into I_MEM while holding the core in reset, then releases the core and monitors its fetch stream. It halts the core on EBREAK, ECALL, an external stop request or a cycle-budget timeout, and reports the halt cause, halt PC and run-cycle count. It sits between the testbench/host loader, the I_MEM write port and the core's reset input.

## Interface
- IMEM_DEPTH, 1024: I_MEM size in 32-bit words; power of two.
- MAX_CYCLES, 32'hFFFF_FFFF: RUN cycle budget before timeout.
- Clock  in  1  single clock.
- Rst  in  1  reset; synchronous, active-high.
- LoadStart  in  1  start request; sampled only in IDLE or HALT.
- LoadLen  in  $clog2(IMEM_DEPTH)+1  words to load; sampled with LoadStart.
- LoadValid  in  1  loader word valid.
- LoadData  in  32  loader word.
- LoadReady  out  1  controller accepts the word.
- StopReq  in  1  external halt request.
- ImemWrEn  out  1  I_MEM write strobe.
- ImemWrAddr  out  32  I_MEM byte address.
- ImemWrData  out  32  I_MEM write data.
- CoreRst  out  1  reset to the core.
- Pc_From_Core  in  32  core fetch PC.
- Instruction_From_Imem  in  32  instruction currently fetched.
- Halted  out  1  state is HALT.
- HaltCause  out  2  0 none, 1 EBREAK/ECALL, 2 StopReq, 3 timeout.
- HaltPc  out  32  Pc_From_Core captured at halt.
- CycleCount  out  32  RUN cycles since last start.

## Operation
- States: IDLE, LOAD, RUN, HALT. Rst forces IDLE from any state, including mid-load or mid-run.
- Reset values: CoreRst=1, LoadReady=0, ImemWrEn=0, Halted=0, HaltCause=0, HaltPc=0, CycleCount=0, word counter=0.
- IDLE/HALT with LoadStart=1:
  - Latch Len = min(LoadLen, IMEM_DEPTH).
  - Clear the word counter and CycleCount. Clear HaltCause and HaltPc.
  - Go to LOAD if Len>0. Go to RUN if Len==0, which runs the existing image.
- LOAD:
  - LoadReady=1 and CoreRst=1.
  - ImemWrEn = LoadValid && LoadReady (combinational). ImemWrAddr = WordCnt<<2. ImemWrData = LoadData.
  - Each accepted word increments WordCnt.
  - Accepting word Len-1 moves to RUN on the next edge. LoadValid gaps stall without penalty.
  - LoadStart is ignored.
- RUN:
  - CoreRst=0, LoadReady=0, and CycleCount increments every cycle.
  - Halt condition 1: Instruction_From_Imem equals 32'h0010_0073 (EBREAK) or 32'h0000_0073 (ECALL).
  - Halt condition 2: StopReq=1.
  - Halt condition 3: CycleCount == MAX_CYCLES-1.
  - When any condition holds, go to HALT. Capture HaltPc = Pc_From_Core of that cycle. Set HaltCause.
  - Priority when conditions coincide: EBREAK/ECALL, then StopReq, then timeout.
  - LoadStart is ignored.
- HALT: CoreRst=1 and Halted=1. HaltCause, HaltPc and CycleCount are held until the next LoadStart.
- StopReq outside RUN has no effect.
- Width rule: CycleCount wraps modulo 2^32, but timeout fires first at the default setting.

## Timing
- The I_MEM write occurs on the same edge as the handshake, with zero-cycle latency.
- Last word accepted at cycle t: RUN at t+1. CoreRst falls at t+1, so the core fetches PC 0 at t+1.
- Halt detected at cycle t: HALT, Halted=1 and CoreRst=1 at t+1. The core executes the instruction at t; EBREAK/ECALL have no architectural side effect in the core.
- CycleCount equals the number of RUN cycles, including the halting cycle.
- Len==0 start: RUN one cycle after LoadStart.
- All outputs are registered except LoadReady, ImemWrEn, ImemWrAddr and ImemWrData, which decode from state, WordCnt and LoadValid.

## Structure
- In rvc_asap_pkg: t_boot_state enum {IDLE, LOAD, RUN, HALT}; t_halt_cause enum {HC_NONE, HC_SYS, HC_STOP, HC_TIMEOUT}; constants EBREAK_INSTR and ECALL_INSTR.
- Registers use the shared RVC_RST_MSFF/RVC_EN_MSFF macros.
- No sub-module; FSM, word counter and cycle counter live in one module.
- The top level wires CoreRst into the core's Rst and muxes ImemWrEn into I_MEM.

## Test plan
- Load 3 words {32'h00500093, 32'h00108113, 32'h00100073} with LoadValid held -> 3 writes at addresses 0, 4, 8 on consecutive cycles. RUN next cycle; HALT with HaltCause=1, HaltPc=8, CycleCount=3.
- Load with LoadValid toggling 1,0,0,1 -> writes only on valid cycles; addresses contiguous; CoreRst stays 1 until the last word.
- LoadLen=2000 with IMEM_DEPTH=1024 -> exactly 1024 writes, last address 32'hFFC; then RUN.
- MAX_CYCLES=10 with a program looping without EBREAK -> HALT after 10 RUN cycles, HaltCause=3, CycleCount=10.
- StopReq and EBREAK fetch in the same RUN cycle -> HaltCause=1. StopReq alone in a later run -> HaltCause=2.
- Rst asserted mid-LOAD after 5 words -> next cycle IDLE, all outputs at reset values. A new LoadStart loads again from address 0.
